// File: rtl/ahb_arb_pkg.sv
// Shared types and constants for the AHB-lite block arbiter.
package ahb_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select: rotate requests to start after the last winner
// (or at index 0 in fixed mode), then priority-encode the lowest rotated slot.
module arb_pick
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last,
  input  logic                   mode,
  output logic [IDX_W-1:0]       winner,
  output logic                   any
);

  logic [IDX_W-1:0]       start;
  logic [NUM_MASTERS-1:0] rot;
  logic [IDX_W-1:0]       rot_idx [NUM_MASTERS];

  always_comb begin
    start = '0;
    if (!mode && (last != IDX_W'(NUM_MASTERS - 1))) begin
      start = last + IDX_W'(1);
    end
  end

  // rot[k] is the request of master (start + k) mod NUM_MASTERS
  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_rot
      logic [IDX_W:0] sum;
      assign sum = {1'b0, start} + (IDX_W + 1)'(gi);
      assign rot_idx[gi] = (sum >= (IDX_W + 1)'(NUM_MASTERS)) ?
                           IDX_W'(sum - (IDX_W + 1)'(NUM_MASTERS)) : sum[IDX_W-1:0];
      assign rot[gi] = req[rot_idx[gi]];
    end
  endgenerate

  always_comb begin
    winner = '0;
    any    = |rot;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (rot[k]) winner = rot_idx[k];
    end
  end

endmodule

// File: rtl/ahb_block_arbiter.sv
// N-master AHB-lite arbiter: grants one master for a full block burst or a
// single word, generating block-aligned beat addresses from a registered beat counter.
module ahb_block_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int BLOCK_WORDS = 4,
  parameter int ADDR_W      = 32,
  parameter int PRIO_MODE   = 0
) (
  input  logic                            HCLK,
  input  logic                            HRESETn,
  input  logic [NUM_MASTERS-1:0]          MRequest,
  input  logic [NUM_MASTERS-1:0]          MSingle,
  input  logic [NUM_MASTERS-1:0]          MWrite,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   MAddr,
  output logic [NUM_MASTERS-1:0]          MReady,
  output logic [$clog2(BLOCK_WORDS)-1:0]  BeatIdx,
  input  logic                            HReady,
  output logic [ADDR_W-1:0]               HAddr,
  output logic                            HWrite,
  output logic                            HRequest,
  output logic [$clog2(NUM_MASTERS)-1:0]  HMaster,
  output logic                            Busy
);

  localparam int BEAT_W = $clog2(BLOCK_WORDS);
  localparam int IDX_W  = $clog2(NUM_MASTERS);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BLOCK_WORDS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_MASTERS - 1);

  arb_state_t       state_reg;
  logic [BEAT_W-1:0] beat_reg;
  logic             len1_reg;
  logic [IDX_W-1:0] last_reg;
  logic [IDX_W-1:0] hmaster_reg;

  logic [IDX_W-1:0]  winner;
  logic              any;
  logic [ADDR_W-1:0] maddr_arr [NUM_MASTERS];
  logic [ADDR_W-1:0] sel_addr;
  logic              xfer;
  logic              last_beat;

  assign xfer      = (state_reg == XFER);
  assign last_beat = len1_reg | (beat_reg == BEAT_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      assign maddr_arr[gi] = MAddr[gi*ADDR_W +: ADDR_W];
      assign MReady[gi]    = xfer & HReady & (hmaster_reg == IDX_W'(gi));
    end
  endgenerate

  arb_pick #(
    .NUM_MASTERS(NUM_MASTERS),
    .IDX_W      (IDX_W)
  ) u_pick (
    .req   (MRequest),
    .last  (last_reg),
    .mode  (PRIO_MODE == PRIO_FIXED),
    .winner(winner),
    .any   (any)
  );

  assign sel_addr = maddr_arr[hmaster_reg];

  // Bursts replace the word offset with the beat so every block starts at word 0
  always_comb begin
    HAddr = '0;
    if (xfer) begin
      if (len1_reg) HAddr = sel_addr;
      else          HAddr = {sel_addr[ADDR_W-1:BEAT_W+2], beat_reg, 2'b00};
    end
  end

  assign HWrite   = xfer & MWrite[hmaster_reg];
  assign HRequest = xfer;
  assign Busy     = xfer;
  assign BeatIdx  = beat_reg;
  assign HMaster  = hmaster_reg;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg   <= IDLE;
      beat_reg    <= '0;
      len1_reg    <= 1'b0;
      last_reg    <= IDX_LAST;
      hmaster_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any) begin
            hmaster_reg <= winner;
            last_reg    <= winner;
            len1_reg    <= MSingle[winner];
            beat_reg    <= '0;
            state_reg   <= XFER;
          end
        end
        XFER: begin
          // Requests are not sampled here; the grant holds until the last beat
          if (HReady) begin
            if (last_beat) begin
              beat_reg  <= '0;
              state_reg <= IDLE;
            end else begin
              beat_reg <= beat_reg + BEAT_W'(1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_block_arbiter.sv
// Randomised bench for ahb_block_arbiter: three instances (2-master RR, 2-master
// fixed, 3-master/8-word RR) checked beat by beat against a transaction-level model.
module tb_ahb_block_arbiter;

  typedef struct {
    int          m;
    logic [31:0] addr;
    bit          single;
    bit          write;
  } txn_t;

  typedef struct {
    int          m;
    logic [31:0] addr;
    bit          write;
    int          idx;
    bit          lst;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cfg = 0;
  logic [2:0]  mr = '0, ms = '0, mw = '0;
  logic [95:0] ma = '0;
  logic        hready = 1'b0;

  logic [1:0]  a_mready, b_mready;
  logic [2:0]  c_mready;
  logic [1:0]  a_beat, b_beat;
  logic [2:0]  c_beat;
  logic [31:0] a_haddr, b_haddr, c_haddr;
  logic        a_hwrite, b_hwrite, c_hwrite;
  logic        a_hreq, b_hreq, c_hreq;
  logic [0:0]  a_hm, b_hm;
  logic [1:0]  c_hm;
  logic        a_busy, b_busy, c_busy;

  logic [2:0]  o_mready, o_beat;
  logic [31:0] o_haddr;
  logic        o_hwrite, o_hreq, o_busy;
  logic [1:0]  o_hm;

  txn_t  txq[$];
  beat_t expq[$];
  int    model_last[3];
  int    checks = 0;
  int    failures = 0;
  bit    rnd_drop = 0;

  ahb_block_arbiter #(.NUM_MASTERS(2), .BLOCK_WORDS(4), .ADDR_W(32), .PRIO_MODE(0)) dut_a (
    .HCLK(clk), .HRESETn(rst_n),
    .MRequest((cfg == 0) ? mr[1:0] : 2'b00), .MSingle(ms[1:0]), .MWrite(mw[1:0]),
    .MAddr(ma[63:0]), .MReady(a_mready), .BeatIdx(a_beat), .HReady(hready),
    .HAddr(a_haddr), .HWrite(a_hwrite), .HRequest(a_hreq), .HMaster(a_hm), .Busy(a_busy)
  );

  ahb_block_arbiter #(.NUM_MASTERS(2), .BLOCK_WORDS(4), .ADDR_W(32), .PRIO_MODE(1)) dut_b (
    .HCLK(clk), .HRESETn(rst_n),
    .MRequest((cfg == 1) ? mr[1:0] : 2'b00), .MSingle(ms[1:0]), .MWrite(mw[1:0]),
    .MAddr(ma[63:0]), .MReady(b_mready), .BeatIdx(b_beat), .HReady(hready),
    .HAddr(b_haddr), .HWrite(b_hwrite), .HRequest(b_hreq), .HMaster(b_hm), .Busy(b_busy)
  );

  ahb_block_arbiter #(.NUM_MASTERS(3), .BLOCK_WORDS(8), .ADDR_W(32), .PRIO_MODE(0)) dut_c (
    .HCLK(clk), .HRESETn(rst_n),
    .MRequest((cfg == 2) ? mr : 3'b000), .MSingle(ms), .MWrite(mw),
    .MAddr(ma), .MReady(c_mready), .BeatIdx(c_beat), .HReady(hready),
    .HAddr(c_haddr), .HWrite(c_hwrite), .HRequest(c_hreq), .HMaster(c_hm), .Busy(c_busy)
  );

  always_comb begin
    o_mready = {1'b0, a_mready};
    o_beat   = {1'b0, a_beat};
    o_haddr  = a_haddr;
    o_hwrite = a_hwrite;
    o_hreq   = a_hreq;
    o_hm     = {1'b0, a_hm};
    o_busy   = a_busy;
    if (cfg == 1) begin
      o_mready = {1'b0, b_mready}; o_beat = {1'b0, b_beat}; o_haddr = b_haddr;
      o_hwrite = b_hwrite; o_hreq = b_hreq; o_hm = {1'b0, b_hm}; o_busy = b_busy;
    end else if (cfg == 2) begin
      o_mready = c_mready; o_beat = c_beat; o_haddr = c_haddr;
      o_hwrite = c_hwrite; o_hreq = c_hreq; o_hm = c_hm; o_busy = c_busy;
    end
  end

  function automatic int nm(input int c);
    return (c == 2) ? 3 : 2;
  endfunction

  function automatic int bwords(input int c);
    return (c == 2) ? 8 : 4;
  endfunction

  task automatic add_txn(input int m, input logic [31:0] a, input bit s, input bit w);
    txn_t t;
    t.m = m; t.addr = a; t.single = s; t.write = w;
    txq.push_back(t);
  endtask

  // Serve pending transactions by the pick rule and expand each into its beats
  task automatic build_expected();
    txn_t cp[$];
    beat_t bt;
    int n, bw, last, win, pos;
    logic [31:0] base;
    cp = txq;
    n = nm(cfg);
    bw = bwords(cfg);
    last = model_last[cfg];
    while (cp.size() > 0) begin
      win = -1;
      pos = -1;
      for (int k = 0; k < n && win < 0; k++) begin
        int i;
        i = (cfg == 1) ? k : (last + 1 + k) % n;
        for (int j = 0; j < cp.size(); j++) begin
          if (cp[j].m == i) begin win = i; pos = j; break; end
        end
      end
      last = win;
      if (cp[pos].single) begin
        bt.m = win; bt.addr = cp[pos].addr; bt.write = cp[pos].write; bt.idx = 0; bt.lst = 1'b1;
        expq.push_back(bt);
      end else begin
        base = cp[pos].addr & ~(32'(bw * 4 - 1));
        for (int b = 0; b < bw; b++) begin
          bt.m = win; bt.addr = base | 32'(b * 4); bt.write = cp[pos].write;
          bt.idx = b; bt.lst = (b == bw - 1);
          expq.push_back(bt);
        end
      end
      cp.delete(pos);
    end
    model_last[cfg] = last;
  endtask

  // Masters present their queued transaction; outputs are sampled 1 time unit after negedge
  task automatic run(input int hr_mode, input int budget, input int stop_pulses,
                     output int cycles, output int pulses);
    bit pop_req, prev_last, done;
    int pop_m, act_m;
    beat_t hd;
    logic [2:0] exp_mr;
    pop_req = 0; prev_last = 0; done = 0; pop_m = -1; act_m = -1;
    cycles = 0; pulses = 0;
    while (!done) begin
      @(negedge clk);
      if (pop_req) begin
        for (int j = 0; j < txq.size(); j++) begin
          if (txq[j].m == pop_m) begin txq.delete(j); break; end
        end
        pop_req = 0;
      end
      for (int i = 0; i < 3; i++) begin
        int p;
        p = -1;
        for (int j = 0; j < txq.size(); j++) begin
          if (txq[j].m == i) begin p = j; break; end
        end
        if (p >= 0) begin
          mr[i] = 1'b1; ms[i] = txq[p].single; mw[i] = txq[p].write; ma[i*32 +: 32] = txq[p].addr;
          if (rnd_drop && i == act_m) mr[i] = 1'($urandom_range(0, 1));
        end else begin
          mr[i] = 1'b0; ms[i] = 1'($urandom_range(0, 1)); mw[i] = 1'($urandom_range(0, 1));
          ma[i*32 +: 32] = $urandom;
        end
      end
      case (hr_mode)
        0:       hready = 1'b1;
        1:       hready = (cycles % 3 == 2);
        default: hready = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      cycles++;
      if (prev_last) begin
        checks++;
        if (o_hreq !== 1'b0) begin
          failures++;
          $display("FAIL idle_gap cfg=%0d HRequest=%b want 0", cfg, o_hreq);
        end
      end
      prev_last = 0;
      if (o_hreq === 1'b1) begin
        if (expq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_xfer cfg=%0d HMaster=%0d HAddr=%h want no transfer", cfg, o_hm, o_haddr);
          done = 1;
        end else begin
          hd = expq[0];
          checks++;
          if (o_hm !== 2'(hd.m) || o_haddr !== hd.addr || o_hwrite !== hd.write ||
              o_beat !== 3'(hd.idx) || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL beat_fields cfg=%0d got m=%0d addr=%h w=%b idx=%0d busy=%b want m=%0d addr=%h w=%b idx=%0d busy=1",
                     cfg, o_hm, o_haddr, o_hwrite, o_beat, o_busy, hd.m, hd.addr, hd.write, hd.idx);
          end
          exp_mr = hready ? (3'b001 << hd.m) : 3'b000;
          checks++;
          if (o_mready !== exp_mr) begin
            failures++;
            $display("FAIL mready cfg=%0d got %b want %b", cfg, o_mready, exp_mr);
          end
          if (hready) begin
            void'(expq.pop_front());
            pulses++;
            act_m = hd.m;
            if (hd.lst) begin pop_req = 1; pop_m = hd.m; prev_last = 1; act_m = -1; end
          end
        end
      end else begin
        checks++;
        if (o_haddr !== 32'h0 || o_hwrite !== 1'b0 || o_mready !== 3'b000 ||
            o_busy !== 1'b0 || o_beat !== 3'd0) begin
          failures++;
          $display("FAIL idle_outputs cfg=%0d got addr=%h w=%b mready=%b busy=%b beat=%0d want all 0",
                   cfg, o_haddr, o_hwrite, o_mready, o_busy, o_beat);
        end
      end
      if (!done) begin
        if (stop_pulses > 0 && pulses >= stop_pulses) done = 1;
        else if (!pop_req && txq.size() == 0 && expq.size() == 0 && o_hreq !== 1'b1) done = 1;
        else if (cycles >= budget) begin
          checks++; failures++;
          $display("FAIL timeout cfg=%0d cycles=%0d pending_beats=%0d want 0", cfg, cycles, expq.size());
          done = 1;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      cfg = c;
      #1;
      checks++;
      if (o_hreq !== 1'b0 || o_busy !== 1'b0 || o_mready !== 3'b000 || o_haddr !== 32'h0 ||
          o_hwrite !== 1'b0 || o_hm !== 2'd0 || o_beat !== 3'd0) begin
        failures++;
        $display("FAIL reset_state cfg=%0d got req=%b busy=%b mready=%b addr=%h w=%b hm=%0d beat=%0d want all 0",
                 cfg, o_hreq, o_busy, o_mready, o_haddr, o_hwrite, o_hm, o_beat);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_last = '{1, 1, 2};
    cfg = 0;
  endtask

  task automatic test_single_burst();
    int cyc, pul;
    cfg = 0;
    add_txn(0, 32'h0000_1008, 1'b0, 1'b0);
    build_expected();
    run(0, 100, 0, cyc, pul);
    checks++;
    if (pul != 4 || cyc != 6) begin
      failures++;
      $display("FAIL single_burst pulses=%0d cycles=%0d want pulses=4 cycles=6", pul, cyc);
    end
  endtask

  task automatic test_wait_states();
    int cyc, pul;
    cfg = 0;
    add_txn(0, $urandom, 1'b0, 1'($urandom_range(0, 1)));
    build_expected();
    run(1, 200, 0, cyc, pul);
    checks++;
    if (pul != 4 || cyc < 12) begin
      failures++;
      $display("FAIL wait_states pulses=%0d cycles=%0d want pulses=4 cycles>=12", pul, cyc);
    end
  endtask

  task automatic test_two_master(input int c, input string nm_s);
    int cyc, pul;
    cfg = c;
    for (int k = 0; k < 3; k++) begin
      add_txn(1, $urandom, 1'b0, 1'($urandom_range(0, 1)));
      add_txn(0, $urandom, 1'b0, 1'($urandom_range(0, 1)));
    end
    build_expected();
    run(0, 200, 0, cyc, pul);
    checks++;
    if (pul != 24 || cyc != 31) begin
      failures++;
      $display("FAIL %s pulses=%0d cycles=%0d want pulses=24 cycles=31", nm_s, pul, cyc);
    end
  endtask

  task automatic test_single_xfer();
    int cyc, pul;
    cfg = 0;
    add_txn(1, 32'h0000_2004, 1'b1, 1'b1);
    build_expected();
    run(0, 50, 0, cyc, pul);
    checks++;
    if (pul != 1 || cyc != 3) begin
      failures++;
      $display("FAIL single_xfer pulses=%0d cycles=%0d want pulses=1 cycles=3", pul, cyc);
    end
  endtask

  task automatic test_reset_mid_burst();
    int cyc, pul;
    cfg = 0;
    add_txn(0, 32'h0000_3010, 1'b0, 1'b1);
    build_expected();
    run(0, 50, 2, cyc, pul);
    @(posedge clk);
    #1;
    checks++;
    if (o_hreq !== 1'b1 || o_beat !== 3'd2) begin
      failures++;
      $display("FAIL pre_reset_beat req=%b beat=%0d want req=1 beat=2", o_hreq, o_beat);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_hreq !== 1'b0 || o_busy !== 1'b0 || o_mready !== 3'b000 || o_haddr !== 32'h0 ||
        o_hwrite !== 1'b0 || o_hm !== 2'd0 || o_beat !== 3'd0) begin
      failures++;
      $display("FAIL async_reset got req=%b busy=%b mready=%b addr=%h w=%b hm=%0d beat=%0d want all 0",
               o_hreq, o_busy, o_mready, o_haddr, o_hwrite, o_hm, o_beat);
    end
    mr = '0;
    txq.delete();
    expq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_last = '{1, 1, 2};
    add_txn(1, $urandom, 1'b0, 1'b0);
    add_txn(0, $urandom, 1'b0, 1'b1);
    build_expected();
    run(2, 200, 0, cyc, pul);
    checks++;
    if (pul != 8) begin
      failures++;
      $display("FAIL post_reset pulses=%0d want 8", pul);
    end
  endtask

  task automatic test_three_masters();
    int cyc, pul;
    cfg = 2;
    add_txn(2, $urandom, 1'b0, 1'b0);
    add_txn(1, $urandom, 1'b0, 1'b1);
    add_txn(0, $urandom, 1'b0, 1'b0);
    build_expected();
    run(0, 200, 0, cyc, pul);
    checks++;
    if (pul != 24 || cyc != 28) begin
      failures++;
      $display("FAIL three_masters pulses=%0d cycles=%0d want pulses=24 cycles=28", pul, cyc);
    end
  endtask

  task automatic test_random();
    int cyc, pul, ntx, want;
    rnd_drop = 1;
    for (int r = 0; r < 8; r++) begin
      cfg = $urandom_range(0, 2);
      ntx = $urandom_range(3, 8);
      for (int k = 0; k < ntx; k++) begin
        add_txn($urandom_range(0, nm(cfg) - 1), $urandom, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
      end
      build_expected();
      want = expq.size();
      run(2, 3000, 0, cyc, pul);
      checks++;
      if (pul != want) begin
        failures++;
        $display("FAIL random_round r=%0d cfg=%0d pulses=%0d want %0d", r, cfg, pul, want);
      end
    end
    rnd_drop = 0;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_wait_states();
    test_two_master(0, "round_robin");
    test_two_master(1, "fixed_prio");
    test_single_xfer();
    test_reset_mid_burst();
    test_three_masters();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
